hyperbus_burst_splitter: RTL and testbench
==========================================

Name: hyperbus_burst_splitter

Overview:
Sits between the AXI slave front-end and the HyperBus PHY transaction FSM inside hyperbus. Accepts one AXI address beat (AW or AR, already arbitrated) and issues one or more HyperBus transactions. Each transaction respects the per-transaction word limit (CS# low-time bound) and never crosses a chip-select device boundary. It also maps the register space (addr[31]=1) and non-INCR bursts onto single-word transactions.

Parameters:
AW, 32, AXI address width
LW, 8, AXI len width
IW, 4, AXI ID width
NR_CS, 2, number of HyperBus devices/chip selects
CS_ADDR_LSB, 23, lowest byte-address bit selecting the device (8 MiB per device)
MAX_WORDS, 128, max 16-bit words per HyperBus transaction; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ax_valid_i  in  1  address beat valid
ax_ready_o  out  1  address beat accepted
ax_addr_i  in  AW  AXI byte address; bit 0 ignored
ax_len_i  in  LW  AXI len (beats-1)
ax_burst_i  in  2  AXI burst type: 00 FIXED, 01 INCR, 10 WRAP
ax_id_i  in  IW  AXI ID
ax_write_i  in  1  1 = write, 0 = read
trans_valid_o  out  1  transaction valid
trans_ready_i  in  1  PHY FSM accepts transaction
trans_addr_o  out  AW  byte address within device: addr[CS_ADDR_LSB-1:0] zero-extended, bit 0 = 0; register space: addr[CS_ADDR_LSB-1:1],0
trans_cs_o  out  NR_CS  one-hot chip select
trans_words_o  out  $clog2(MAX_WORDS+1)  word count, 1..MAX_WORDS
trans_reg_o  out  1  register-space access
trans_write_o  out  1  write transaction
trans_id_o  out  IW  latched AXI ID
trans_last_o  out  1  final transaction of this AXI burst

Behaviour:
- Reset (async, rst_ni low): state IDLE; ax_ready_o=1; trans_valid_o=0; all other trans_* outputs 0. Reset mid-SPLIT aborts the burst with no trailing transaction.
- States:
  - IDLE: ax_ready_o=1, trans_valid_o=0. On ax_valid_i & ax_ready_o, latch addr (bit 0 cleared), ID, write, reg = addr[31], remaining = len+1. Set single = (burst==FIXED) | reg. Go to SPLIT. WRAP is handled as INCR (documented limitation).
  - SPLIT: ax_ready_o=0, trans_valid_o=1. Outputs are registered/stable while trans_ready_i is low.
- Device index = addr[CS_ADDR_LSB +: clog2(NR_CS)]. trans_cs_o = 1 << index. Register space uses the same decode.
- Word count: single: 1. Otherwise: min(remaining, MAX_WORDS, (2^CS_ADDR_LSB - addr[CS_ADDR_LSB-1:0]) / 2).
- trans_last_o = (remaining == trans_words_o).
- On trans_valid_o & trans_ready_i:
  - remaining -= words.
  - If not single: addr += 2*words (full AW-bit add; a carry into the CS field selects the next device).
  - If last: go to IDLE.
- Latency: accept at edge N gives trans_valid_o high after edge N (visible in cycle N+1). After the last handshake, one IDLE cycle before the next accept (no back-to-back accept).
- Device index >= NR_CS: trans_cs_o = 0 and the transaction is still issued. The PHY returns SLVERR; this block only forwards.
- len=0: exactly one transaction, trans_last_o=1.

Test Plan:
1. Write, addr 0x0, len 60, INCR, ID 9 -> one transaction: addr 0x0, words 61, cs 01, write 1, id 9, last 1.
2. Read, addr 0x0, len 222, INCR -> trans A: addr 0x0, words 128, last 0; trans B: addr 0x100, words 95, last 1.
3. Write, addr 0x7FFFF0, len 15, INCR -> trans A: addr 0x7FFFF0, cs 01, words 8, last 0; trans B: addr 0x0, cs 10, words 8, last 1.
4. Read, addr 0x80000800, len 0 -> reg 1, addr 0x800, cs 01, words 1, last 1. Same with len 2 -> three 1-word transactions at 0x800, last only on the third.
5. FIXED, addr 0x101, len 2 -> three transactions at addr 0x100, words 1; address does not advance. Then hold trans_ready_i low 5 cycles -> all trans_* stable and ax_ready_o=0 throughout.
6. Drop rst_ni during trans B of scenario 2 -> trans_valid_o=0 and ax_ready_o=1 asynchronously. After release, a new len-0 request yields one transaction at the new address.

Source files
------------

// File: rtl/hyperbus_burst_splitter.sv
// hyperbus_burst_splitter: splits one AXI address beat into HyperBus transactions bounded by MAX_WORDS and device boundaries
//   ax_*    : AXI address beat in (valid/ready, addr, len, burst, id, write)
//   trans_* : HyperBus transaction out (valid/ready, in-device addr, one-hot cs, word count, reg, write, id, last)
module hyperbus_burst_splitter #(
  parameter int AW          = 32,
  parameter int LW          = 8,
  parameter int IW          = 4,
  parameter int NR_CS       = 2,
  parameter int CS_ADDR_LSB = 23,
  parameter int MAX_WORDS   = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ax_valid_i,
  output logic                           ax_ready_o,
  input  logic [AW-1:0]                  ax_addr_i,
  input  logic [LW-1:0]                  ax_len_i,
  input  logic [1:0]                     ax_burst_i,
  input  logic [IW-1:0]                  ax_id_i,
  input  logic                           ax_write_i,
  output logic                           trans_valid_o,
  input  logic                           trans_ready_i,
  output logic [AW-1:0]                  trans_addr_o,
  output logic [NR_CS-1:0]               trans_cs_o,
  output logic [$clog2(MAX_WORDS+1)-1:0] trans_words_o,
  output logic                           trans_reg_o,
  output logic                           trans_write_o,
  output logic [IW-1:0]                  trans_id_o,
  output logic                           trans_last_o
);
  localparam int WW  = $clog2(MAX_WORDS + 1);
  localparam int IXW = NR_CS > 1 ? $clog2(NR_CS) : 1;
  localparam int DW  = 2 ** IXW;
  localparam int RW  = LW + 1;
  localparam int NW0 = (CS_ADDR_LSB + 1 > RW) ? CS_ADDR_LSB + 1 : RW;
  localparam int NW  = NW0 > WW ? NW0 : WW;
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   id_q, id_d;
  logic            write_q, write_d, reg_q, reg_d, single_q, single_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [NW-1:0]   room, cap, words;
  logic [IXW-1:0]  idx;
  logic [DW-1:0]   dec;
  logic            split, last;
  always_comb begin
    // words left before the device boundary; addr_q[0] is always 0
    room  = NW'(({1'b1, {CS_ADDR_LSB{1'b0}}} - {1'b0, addr_q[CS_ADDR_LSB-1:0]}) >> 1);
    cap   = NW'(rem_q) < NW'(MAX_WORDS) ? NW'(rem_q) : NW'(MAX_WORDS);
    words = single_q ? NW'(1) : (cap < room ? cap : room);
    split = state_q == SPLIT;
    last  = NW'(rem_q) == words;
    idx   = addr_q[CS_ADDR_LSB +: IXW];
    // indices beyond NR_CS shift out of the kept slice, giving cs = 0
    dec   = DW'(1) << idx;
  end
  assign ax_ready_o    = !split;
  assign trans_valid_o = split;
  assign trans_addr_o  = split ? AW'({addr_q[CS_ADDR_LSB-1:1], 1'b0}) : '0;
  assign trans_cs_o    = split ? dec[NR_CS-1:0] : '0;
  assign trans_words_o = split ? WW'(words) : '0;
  assign trans_reg_o   = split & reg_q;
  assign trans_write_o = split & write_q;
  assign trans_id_o    = split ? id_q : '0;
  assign trans_last_o  = split & last;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    write_d  = write_q;
    reg_d    = reg_q;
    single_d = single_q;
    rem_d    = rem_q;
    if (!split && ax_valid_i) begin
      state_d  = SPLIT;
      addr_d   = ax_addr_i & ~AW'(1);
      id_d     = ax_id_i;
      write_d  = ax_write_i;
      reg_d    = ax_addr_i[AW-1];
      // WRAP is treated as INCR
      single_d = (ax_burst_i == 2'b00) | ax_addr_i[AW-1];
      rem_d    = RW'(ax_len_i) + RW'(1);
    end else if (split && trans_ready_i) begin
      rem_d   = rem_q - RW'(words);
      // full-width add so a carry into the CS field moves to the next device
      addr_d  = single_q ? addr_q : addr_q + (AW'(words) << 1);
      state_d = last ? IDLE : SPLIT;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      write_q  <= 1'b0;
      reg_q    <= 1'b0;
      single_q <= 1'b0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      write_q  <= write_d;
      reg_q    <= reg_d;
      single_q <= single_d;
      rem_q    <= rem_d;
    end
  end
endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// tb_hyperbus_burst_splitter: table-driven scoreboard bench for hyperbus_burst_splitter
module tb_hyperbus_burst_splitter;
  logic        clk = 0, rst_n = 0;
  logic        ax_valid = 0, ax_ready, ax_write = 0;
  logic [31:0] ax_addr = 0;
  logic [7:0]  ax_len = 0;
  logic [1:0]  ax_burst = 0;
  logic [3:0]  ax_id = 0;
  logic        trans_valid, trans_ready = 0;
  logic [31:0] trans_addr;
  logic [1:0]  trans_cs;
  logic [7:0]  trans_words;
  logic        trans_reg, trans_write, trans_last;
  logic [3:0]  trans_id;
  int          pass = 0, total = 0;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  cs;
    logic [7:0]  words;
    logic        rg;
    logic        wr;
    logic [3:0]  id;
    logic        last;
  } tr_t;
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic        wr;
    int          n;
    tr_t         t[3];
  } vec_t;
  vec_t vt[8];
  int   nv = 0;
  tr_t  sb[$];
  hyperbus_burst_splitter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ax_valid_i(ax_valid), .ax_ready_o(ax_ready), .ax_addr_i(ax_addr), .ax_len_i(ax_len),
    .ax_burst_i(ax_burst), .ax_id_i(ax_id), .ax_write_i(ax_write),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_addr_o(trans_addr),
    .trans_cs_o(trans_cs), .trans_words_o(trans_words), .trans_reg_o(trans_reg),
    .trans_write_o(trans_write), .trans_id_o(trans_id), .trans_last_o(trans_last)
  );
  always #5 clk = ~clk;
  function automatic tr_t mk(logic [31:0] a, logic [1:0] cs, logic [7:0] w, logic rg, logic last);
    tr_t t;
    t.addr = a; t.cs = cs; t.words = w; t.rg = rg; t.last = last; t.wr = 0; t.id = 0;
    return t;
  endfunction
  task automatic add(logic [31:0] a, logic [7:0] l, logic [1:0] b, logic [3:0] id, logic wr, int n, tr_t t0, tr_t t1, tr_t t2);
    vt[nv].addr = a; vt[nv].len = l; vt[nv].burst = b; vt[nv].id = id; vt[nv].wr = wr; vt[nv].n = n;
    vt[nv].t[0] = t0; vt[nv].t[1] = t1; vt[nv].t[2] = t2;
    nv++;
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cmp_tr(tr_t e);
    chk("addr", trans_addr, e.addr);
    chk("cs", trans_cs, e.cs);
    chk("words", trans_words, e.words);
    chk("reg", trans_reg, e.rg);
    chk("write", trans_write, e.wr);
    chk("id", trans_id, e.id);
    chk("last", trans_last, e.last);
  endtask
  task automatic send(vec_t v);
    tr_t t;
    @(negedge clk);
    chk("ax_ready", ax_ready, 1);
    ax_valid = 1; ax_addr = v.addr; ax_len = v.len; ax_burst = v.burst; ax_id = v.id; ax_write = v.wr;
    for (int j = 0; j < v.n; j++) begin
      t = v.t[j]; t.wr = v.wr; t.id = v.id;
      sb.push_back(t);
    end
    @(posedge clk);
    #1 ax_valid = 0;
  endtask
  task automatic consume(int hold_idx);
    tr_t e;
    int  cyc, k;
    k = 0;
    while (sb.size() > 0) begin
      cyc = 0;
      @(negedge clk);
      while (!trans_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      e = sb.pop_front();
      if (k == 0) chk("latency", cyc, 0);
      if (!trans_valid) begin
        chk("valid_timeout", 0, 1);
        sb.delete();
        break;
      end
      cmp_tr(e);
      if (k == hold_idx)
        repeat (5) begin
          @(negedge clk);
          cmp_tr(e);
          chk("hold_valid", trans_valid, 1);
          chk("hold_ax_ready", ax_ready, 0);
        end
      trans_ready = 1;
      @(posedge clk);
      #1 trans_ready = 0;
      k++;
    end
    @(negedge clk);
    chk("idle_valid", trans_valid, 0);
    chk("idle_ax_ready", ax_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tr_t z, e;
    vec_t v;
    z = mk(0, 0, 0, 0, 0);
    add(32'h0, 60, 2'b01, 9, 1, 1, mk(32'h0, 2'b01, 61, 0, 1), z, z);
    add(32'h0, 222, 2'b01, 3, 0, 2, mk(32'h0, 2'b01, 128, 0, 0), mk(32'h100, 2'b01, 95, 0, 1), z);
    add(32'h7FFFF0, 15, 2'b01, 5, 1, 2, mk(32'h7FFFF0, 2'b01, 8, 0, 0), mk(32'h0, 2'b10, 8, 0, 1), z);
    add(32'h80000800, 0, 2'b01, 1, 0, 1, mk(32'h800, 2'b01, 1, 1, 1), z, z);
    add(32'h80000800, 2, 2'b01, 2, 0, 3, mk(32'h800, 2'b01, 1, 1, 0), mk(32'h800, 2'b01, 1, 1, 0), mk(32'h800, 2'b01, 1, 1, 1));
    add(32'h0, 127, 2'b01, 11, 1, 1, mk(32'h0, 2'b01, 128, 0, 1), z, z);
    add(32'h00800011, 3, 2'b10, 4, 0, 1, mk(32'h10, 2'b10, 4, 0, 1), z, z);
    add(32'h101, 2, 2'b00, 7, 1, 3, mk(32'h100, 2'b01, 1, 0, 0), mk(32'h100, 2'b01, 1, 0, 0), mk(32'h100, 2'b01, 1, 0, 1));
    #12;
    chk("rst_ax_ready", ax_ready, 1);
    chk("rst_valid", trans_valid, 0);
    chk("rst_cs", trans_cs, 0);
    chk("rst_words", trans_words, 0);
    chk("rst_last", trans_last, 0);
    chk("rst_addr", trans_addr, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < nv - 1; i++) begin
      send(vt[i]);
      consume(-1);
    end
    send(vt[nv-1]);
    consume(1);
    send(vt[1]);
    e = sb.pop_front();
    @(negedge clk);
    chk("rst_seq_valid_a", trans_valid, 1);
    cmp_tr(e);
    trans_ready = 1;
    @(posedge clk);
    #1 trans_ready = 0;
    e = sb.pop_front();
    @(negedge clk);
    cmp_tr(e);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", trans_valid, 0);
    chk("async_rst_ax_ready", ax_ready, 1);
    chk("async_rst_cs", trans_cs, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    v = vt[0];
    v.addr = 32'h00800200; v.len = 0; v.id = 6; v.n = 1;
    v.t[0] = mk(32'h200, 2'b10, 1, 0, 1);
    send(v);
    consume(-1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
